// File: rtl/regression_evaluator_if.sv
// Sample-memory read port and prediction stream shared by the regression evaluator
// and its neighbours (sample memory upstream, prediction consumer downstream).
interface regression_evaluator_if #(
    parameter int W  = 20,
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_X;
    logic [W-1:0]  mem_Y;
    logic          pred_valid;
    logic          pred_ready;
    logic [W-1:0]  pred_y;
    logic [W-1:0]  pred_err;

    modport master (
        output mem_addr,
        input  mem_X,
        input  mem_Y,
        output pred_valid,
        input  pred_ready,
        output pred_y,
        output pred_err
    );

    modport slave (
        input  mem_addr,
        output mem_X,
        output mem_Y,
        input  pred_valid,
        output pred_ready,
        input  pred_y,
        input  pred_err
    );
endinterface

// File: rtl/regression_evaluator.sv
// Re-reads the X/Y dataset with captured coefficients B0/B1, streams y_hat and the
// residual per sample, and accumulates a saturating sum of squared residuals.
module regression_evaluator #(
    parameter int N    = 150,
    parameter int W    = 20,
    parameter int AW   = 8,
    parameter int SSEW = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [W-1:0]           i_b0,
    input  logic [W-1:0]           i_b1,
    regression_evaluator_if.master bus,
    output logic [SSEW-1:0]        o_sse,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int PW   = 2 * W;
    localparam int SUMW = ((SSEW > PW) ? SSEW : PW) + 1;
    localparam logic [SUMW-1:0] SSE_MAX  = {{(SUMW - SSEW){1'b0}}, {SSEW{1'b1}}};
    localparam logic [AW-1:0]   LAST_IDX = AW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMPUTE,
        PRESENT,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_idx;
    logic [W-1:0]    r_b0;
    logic [W-1:0]    r_b1;
    logic [W-1:0]    r_predY;
    logic [W-1:0]    r_predErr;
    logic            r_predValid;
    logic [SSEW-1:0] r_sse;

    logic [W-1:0]    w_prodLo;
    logic [W-1:0]    w_predY;
    logic [W-1:0]    w_err;
    logic [W-1:0]    w_mag;
    logic [PW-1:0]   w_sq;
    logic [SUMW-1:0] w_sum;
    logic [SSEW-1:0] w_sseNext;
    logic            w_accept;

    assign w_accept = r_predValid & bus.pred_ready;

    // Squaring the magnitude of the signed residual gives the same result as a signed
    // square, and keeps the most negative value (magnitude 2^(W-1)) exact.
    always_comb begin
        w_prodLo  = r_b1 * bus.mem_X;
        w_predY   = r_b0 + w_prodLo;
        w_err     = bus.mem_Y - w_predY;
        w_mag     = w_err[W-1] ? (~w_err + W'(1)) : w_err;
        w_sq      = PW'(w_mag) * PW'(w_mag);
        w_sum     = SUMW'(r_sse) + SUMW'(w_sq);
        w_sseNext = (w_sum > SSE_MAX) ? SSE_MAX[SSEW-1:0] : w_sum[SSEW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = FETCH;
            FETCH:   w_next = COMPUTE;
            COMPUTE: w_next = PRESENT;
            PRESENT: if (w_accept) w_next = (r_idx == LAST_IDX) ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The last index is left in place after the final handshake; the next start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_predY     <= '0;
            r_predErr   <= '0;
            r_predValid <= 1'b0;
            r_sse       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_b0  <= i_b0;
                        r_b1  <= i_b1;
                        r_idx <= '0;
                        r_sse <= '0;
                    end
                end
                COMPUTE: begin
                    r_predY     <= w_predY;
                    r_predErr   <= w_err;
                    r_sse       <= w_sseNext;
                    r_predValid <= 1'b1;
                end
                PRESENT: begin
                    if (w_accept) begin
                        r_predValid <= 1'b0;
                        if (r_idx != LAST_IDX) r_idx <= r_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr   = r_idx;
    assign bus.pred_valid = r_predValid;
    assign bus.pred_y     = r_predY;
    assign bus.pred_err   = r_predErr;
    assign o_sse          = r_sse;
    assign o_busy         = (r_state != IDLE);
    assign o_done         = (r_state == DONE);
endmodule

// File: tb/tb_regression_evaluator.sv
// Directed, table-driven bench for regression_evaluator using three instances sized
// N=2, N=5 and N=1 that share one clock, one reset and one dataset table.
module tb_regression_evaluator;
    localparam int W    = 20;
    localparam int AW   = 8;
    localparam int SSEW = 40;

    typedef struct {
        logic [W-1:0]    x;
        logic [W-1:0]    y;
        logic [W-1:0]    expY;
        logic [W-1:0]    expErr;
        logic [SSEW-1:0] expSse;
    } vec_t;

    logic clk;
    logic rst;
    logic startDrv;
    logic readyDrv;
    logic [W-1:0] b0Drv;
    logic [W-1:0] b1Drv;
    int sel;

    logic [W-1:0] dataX [0:255];
    logic [W-1:0] dataY [0:255];
    vec_t tbl [0:8];

    int assertCount;
    int failCount;

    regression_evaluator_if #(.W(W), .AW(AW)) ifA ();
    regression_evaluator_if #(.W(W), .AW(AW)) ifB ();
    regression_evaluator_if #(.W(W), .AW(AW)) ifC ();

    logic startA, startB, startC;
    logic [SSEW-1:0] sseA, sseB, sseC;
    logic busyA, busyB, busyC;
    logic doneA, doneB, doneC;

    assign startA = startDrv && (sel == 0);
    assign startB = startDrv && (sel == 1);
    assign startC = startDrv && (sel == 2);
    assign ifA.pred_ready = readyDrv;
    assign ifB.pred_ready = readyDrv;
    assign ifC.pred_ready = readyDrv;

    regression_evaluator #(.N(2), .W(W), .AW(AW), .SSEW(SSEW)) dutA (
        .clk(clk), .rst(rst), .i_start(startA), .i_b0(b0Drv), .i_b1(b1Drv),
        .bus(ifA), .o_sse(sseA), .o_busy(busyA), .o_done(doneA)
    );
    regression_evaluator #(.N(5), .W(W), .AW(AW), .SSEW(SSEW)) dutB (
        .clk(clk), .rst(rst), .i_start(startB), .i_b0(b0Drv), .i_b1(b1Drv),
        .bus(ifB), .o_sse(sseB), .o_busy(busyB), .o_done(doneB)
    );
    regression_evaluator #(.N(1), .W(W), .AW(AW), .SSEW(SSEW)) dutC (
        .clk(clk), .rst(rst), .i_start(startC), .i_b0(b0Drv), .i_b1(b1Drv),
        .bus(ifC), .o_sse(sseC), .o_busy(busyC), .o_done(doneC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample memory: registered read, data valid the cycle after the address
    always @(posedge clk) begin
        ifA.mem_X <= dataX[ifA.mem_addr];
        ifA.mem_Y <= dataY[ifA.mem_addr];
        ifB.mem_X <= dataX[ifB.mem_addr];
        ifB.mem_Y <= dataY[ifB.mem_addr];
        ifC.mem_X <= dataX[ifC.mem_addr];
        ifC.mem_Y <= dataY[ifC.mem_addr];
    end

    logic            obsValid;
    logic [W-1:0]    obsY;
    logic [W-1:0]    obsErr;
    logic [SSEW-1:0] obsSse;
    logic            obsBusy;
    logic            obsDone;
    logic [AW-1:0]   obsAddr;

    always_comb begin
        obsValid = ifA.pred_valid;
        obsY     = ifA.pred_y;
        obsErr   = ifA.pred_err;
        obsSse   = sseA;
        obsBusy  = busyA;
        obsDone  = doneA;
        obsAddr  = ifA.mem_addr;
        case (sel)
            1: begin
                obsValid = ifB.pred_valid;
                obsY     = ifB.pred_y;
                obsErr   = ifB.pred_err;
                obsSse   = sseB;
                obsBusy  = busyB;
                obsDone  = doneB;
                obsAddr  = ifB.mem_addr;
            end
            2: begin
                obsValid = ifC.pred_valid;
                obsY     = ifC.pred_y;
                obsErr   = ifC.pred_err;
                obsSse   = sseC;
                obsBusy  = busyC;
                obsDone  = doneC;
                obsAddr  = ifC.mem_addr;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 64'(obsValid), 64'd0);
        checkOutput({tag, "_sse"}, 64'(obsSse), 64'd0);
        checkOutput({tag, "_busy"}, 64'(obsBusy), 64'd0);
        checkOutput({tag, "_done"}, 64'(obsDone), 64'd0);
        checkOutput({tag, "_pred_y"}, 64'(obsY), 64'd0);
        checkOutput({tag, "_pred_err"}, 64'(obsErr), 64'd0);
        checkOutput({tag, "_addr"}, 64'(obsAddr), 64'd0);
    endtask

    // Runs one evaluation of cnt samples starting at tbl[base] on instance dut.
    // stall: cycles of pred_ready=0 on the first prediction. poke: pulse start and
    // change B0/B1 mid-run, and assert start while the instance is in DONE.
    task automatic applyStimulus(input int dut, input int base, input int cnt,
                                 input logic [W-1:0] b0, input logic [W-1:0] b1,
                                 input int stall, input int doneAt, input bit poke);
        int s;
        int t;
        int stallLeft;
        bit seenDone;
        bit seenValid;
        bit holding;
        logic [SSEW-1:0] finalSse;
        s = 0;
        t = 0;
        stallLeft = stall;
        seenDone = 1'b0;
        seenValid = 1'b0;
        holding = 1'b0;
        finalSse = tbl[base + cnt - 1].expSse;
        for (int j = 0; j < cnt; j++) begin
            dataX[j] = tbl[base + j].x;
            dataY[j] = tbl[base + j].y;
        end
        @(negedge clk);
        sel = dut;
        b0Drv = b0;
        b1Drv = b1;
        readyDrv = 1'b1;
        startDrv = 1'b1;
        @(negedge clk);
        startDrv = 1'b0;
        t = 1;
        while (!seenDone && t < 200) begin
            if (poke && t == 4) begin
                startDrv = 1'b1;
                b0Drv = 20'h12345;
                b1Drv = 20'h00777;
            end else if (poke && t == 5) begin
                startDrv = 1'b0;
            end
            checkOutput("busy_run", 64'(obsBusy), 64'd1);
            if (holding) checkOutput("hold_valid", 64'(obsValid), 64'd1);
            holding = 1'b0;
            if (obsDone) begin
                checkOutput("done_time", 64'(t), 64'(doneAt));
                checkOutput("accepted_count", 64'(s), 64'(cnt));
                checkOutput("final_sse", 64'(obsSse), 64'(finalSse));
                seenDone = 1'b1;
                if (poke) startDrv = 1'b1;
            end else if (obsValid) begin
                if (!seenValid) begin
                    checkOutput("first_valid_time", 64'(t), 64'd3);
                    seenValid = 1'b1;
                end
                if (s < cnt) begin
                    checkOutput("pred_y", 64'(obsY), 64'(tbl[base + s].expY));
                    checkOutput("pred_err", 64'(obsErr), 64'(tbl[base + s].expErr));
                    checkOutput("sse", 64'(obsSse), 64'(tbl[base + s].expSse));
                end else begin
                    checkOutput("extra_valid", 64'(s), 64'(cnt - 1));
                end
                if (stallLeft > 0) begin
                    readyDrv = 1'b0;
                    stallLeft--;
                    holding = 1'b1;
                end else begin
                    readyDrv = 1'b1;
                    s++;
                end
            end
            @(negedge clk);
            t++;
        end
        if (!seenDone) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            startDrv = 1'b0;
            checkOutput("done_pulse_width", 64'(obsDone), 64'd0);
            checkOutput("busy_after_done", 64'(obsBusy), 64'd0);
            checkOutput("sse_hold", 64'(obsSse), 64'(finalSse));
            @(negedge clk);
            checkOutput("no_restart_from_done", 64'(obsBusy), 64'd0);
            checkOutput("sse_hold_idle", 64'(obsSse), 64'(finalSse));
        end
        readyDrv = 1'b1;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0;
        failCount = 0;
        rst = 1'b1;
        startDrv = 1'b0;
        readyDrv = 1'b1;
        b0Drv = '0;
        b1Drv = '0;
        sel = 0;
        for (int j = 0; j < 256; j++) begin
            dataX[j] = '0;
            dataY[j] = '0;
        end

        // {x, y, expected y_hat, expected residual, expected running sse}
        tbl[0] = '{20'd5, 20'd25, 20'd20, 20'd5, 40'd25};
        tbl[1] = '{20'd3, 20'd10, 20'd16, 20'hFFFFA, 40'd61};
        tbl[2] = '{20'd0, 20'h7FFFF, 20'd0, 20'h7FFFF, 40'd274876858369};
        tbl[3] = '{20'd0, 20'h7FFFF, 20'd0, 20'h7FFFF, 40'd549753716738};
        tbl[4] = '{20'd0, 20'h7FFFF, 20'd0, 20'h7FFFF, 40'd824630575107};
        tbl[5] = '{20'd0, 20'h7FFFF, 20'd0, 20'h7FFFF, 40'd1099507433476};
        tbl[6] = '{20'd0, 20'h7FFFF, 20'd0, 20'h7FFFF, 40'hFFFFFFFFFF};
        tbl[7] = '{20'd2, 20'd0, 20'h00001, 20'hFFFFF, 40'd1};
        tbl[8] = '{20'd0, 20'd0, 20'h80000, 20'h80000, 40'd274877906944};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            checkIdle("reset");
        end
        rst = 1'b0;

        $display("[TB] basic run");
        applyStimulus(0, 0, 2, 20'd10, 20'd2, 0, 7, 1'b0);
        $display("[TB] backpressure run");
        applyStimulus(0, 0, 2, 20'd10, 20'd2, 4, 11, 1'b0);
        $display("[TB] start and coefficient handling run");
        applyStimulus(0, 0, 2, 20'd10, 20'd2, 0, 7, 1'b1);
        $display("[TB] saturation run");
        applyStimulus(1, 2, 5, 20'd0, 20'd0, 0, 16, 1'b0);
        $display("[TB] wrap run");
        applyStimulus(2, 7, 1, 20'hFFFFF, 20'd1, 0, 4, 1'b0);
        $display("[TB] most negative residual run");
        applyStimulus(2, 8, 1, 20'h80000, 20'd0, 0, 4, 1'b0);

        // Reset while the second prediction is being presented
        $display("[TB] reset mid-run");
        dataX[0] = 20'd5;
        dataY[0] = 20'd25;
        dataX[1] = 20'd3;
        dataY[1] = 20'd10;
        @(negedge clk);
        sel = 0;
        b0Drv = 20'd10;
        b1Drv = 20'd2;
        readyDrv = 1'b1;
        startDrv = 1'b1;
        @(negedge clk);
        startDrv = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mid_valid", 64'(obsValid), 64'd1);
        checkOutput("mid_pred_y", 64'(obsY), 64'd16);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("abort");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(obsDone), 64'd0);
        end
        applyStimulus(0, 0, 2, 20'd10, 20'd2, 0, 7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/regression_evaluator.md
Name: regression_evaluator

Overview:
- Downstream consumer of the regression coefficient stage.
- On start, captures the fitted coefficients B0 and B1, then re-reads the same N-sample X/Y dataset from the sample memory.
- For each sample it produces the prediction y_hat = B0 + B1*X and the residual e = Y - y_hat, and streams both out over a valid/ready handshake.
- It accumulates the sum of squared residuals (SSE) and pulses done when the last residual has been accepted.

Parameters:
N, 150, number of samples per dataset
W, 20, data and coefficient width
AW, 8, sample memory address width; must satisfy 2^AW >= N
SSEW, 40, SSE accumulator width

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin an evaluation; sampled only in IDLE
B0  input  W  intercept, unsigned; captured on the start cycle
B1  input  W  slope, unsigned; captured on the start cycle
mem_addr  output  AW  sample index driven to the sample memory
mem_X  input  W  X[mem_addr], valid one cycle after mem_addr is driven
mem_Y  input  W  Y[mem_addr], valid one cycle after mem_addr is driven
pred_valid  output  1  pred_y and pred_err are valid
pred_ready  input  1  downstream accepts the current prediction
pred_y  output  W  prediction y_hat
pred_err  output  W  residual, two's complement
sse  output  SSEW  running/final sum of squared residuals, saturating
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset: one synchronous, active-high reset applies.
  - State goes to IDLE; the index register clears to 0.
  - pred_valid=0, pred_y=0, pred_err=0, sse=0, done=0, busy=0, mem_addr=0.
  - Reset asserted mid-run aborts the run immediately. No done pulse is issued and no partial result is kept.
- States: IDLE, FETCH, COMPUTE, PRESENT, DONE.
- IDLE:
  - If start=1: capture B0/B1 into internal registers, clear idx and sse, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_addr = idx (mem_addr is driven from the idx register in every state).
  - Unconditionally go to COMPUTE.
- COMPUTE: mem_X and mem_Y are valid. At the clock edge:
  - pred_y <= (B0 + (B1*mem_X)[W-1:0]) mod 2^W.
  - pred_err <= (mem_Y - pred_y_comb) mod 2^W, where pred_y_comb is the combinational value being loaded into pred_y.
  - sse <= min(sse + e*e, 2^SSEW-1), with e taken as a signed W-bit value and e*e as an unsigned 2W-bit product.
  - pred_valid <= 1; go to PRESENT.
- PRESENT:
  - pred_y, pred_err and pred_valid are held stable while pred_ready=0.
  - On pred_valid & pred_ready: pred_valid <= 0.
  - If idx == N-1, go to DONE. Otherwise idx <= idx+1 and go to FETCH.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - sse holds its final value until the next accepted start or reset.
- Timing:
  - Fixed cost is 3 cycles per sample when pred_ready=1.
  - First pred_valid goes high 2 cycles after the start edge.
  - done is high in the cycle that begins 3N edges after the start edge.
- start:
  - Ignored in every state except IDLE.
  - start=1 during DONE is ignored; it must be reasserted once the block is in IDLE.
- B0/B1 inputs may change after the start cycle without effect; only the captured values are used.
- Arithmetic rules:
  - All wrap is modulo 2^W except the SSE.
  - The SSE saturates and stays at all-ones once reached; it never wraps.
  - The most negative residual (0x80000 when W=20) squares to 2^38.
- pred_ready held high while pred_valid=0 has no effect.

Test Plan:
- Basic: N=2, B0=10, B1=2, samples (X=5,Y=25) and (X=3,Y=10), pred_ready=1.
  - Required response: pred_y=20, pred_err=5, then pred_y=16, pred_err=0xFFFFA.
  - Final sse=61; done pulses at start edge +6.
- Backpressure: same data, pred_ready held 0 for 4 cycles on the first prediction.
  - Required response: pred_y=20 and pred_err=5 stay stable with pred_valid=1 throughout.
  - sse=25 until the second COMPUTE; done is delayed by exactly 4 cycles.
- Saturation: N=5, B0=0, B1=0, every sample X=0, Y=0x7FFFF.
  - Required response: after 4 samples sse=1099507433476.
  - After the 5th, sse=0xFFFFFFFFFF and it stays there.
- Wrap: N=1, B0=0xFFFFF, B1=1, X=2, Y=0.
  - Required response: pred_y=0x00001, pred_err=0xFFFFF, sse=1.
- Start and coefficient handling: pulse start again mid-run, and change B0/B1 after start.
  - Required response: no restart, outputs unchanged, busy=1 until after done.
  - A start asserted during DONE is ignored.
- Reset mid-run: assert rst in PRESENT of the 2nd sample.
  - Required response: the next cycle shows pred_valid=0, sse=0, busy=0, and no done pulse.
  - A following start runs cleanly from idx 0.
